point_writeback: RTL and testbench
==================================

Name: point_writeback

Overview:
- Downstream stage of the pointwise (1x1) convolution controller.
- Consumes the MAC array's partial sums for each output pixel and accumulates them across input-channel groups.
- Requantizes the result to 8 bits and applies the selected activation (none/ReLU/hard-swish).
- Issues one write per output pixel to the output feature buffer and pulses a done flag when the layer is complete.

Parameters:
PSUM_W, 20, signed partial-sum and accumulator width
DATA_W, 8, signed output activation width
ADDR_W, 14, output buffer address width
FRAC, 4, fractional bits of the output fixed-point format
HS_MUL, 171, reciprocal-of-6 multiplier for hard-swish, scaled by 2^10

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches config while IDLE
out_base  in  ADDR_W  first output buffer address
filter_channel_max  in  4  channel groups per output pixel (count; 0 treated as 1)
filter_number_max  in  6  number of filters (count)
window_size_max  in  14  output pixels per filter (count)
out_shift  in  5  requantization right-shift amount
act_mode  in  2  0 none, 1 ReLU, 2 hard-swish, 3 treated as none
psum_valid  in  1  partial-sum strobe
psum_data  in  PSUM_W  signed partial sum
wr_en  out  1  output buffer write strobe
wr_addr  out  ADDR_W  output buffer write address
wr_data  out  DATA_W  activated output value
busy  out  1  high from the start edge until wb_done
wb_done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-low. While rst=0, all state clears, the FSM goes to IDLE, and wr_en, wr_addr, wr_data, busy and wb_done are all 0. A reset mid-layer abandons the layer; no write or done pulse follows.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch all config inputs, clear the counters (grp, pix, filt), set the address counter to out_base, then go to RUN. busy rises on the same edge.
  - RUN: each psum_valid is accepted. If grp==0, acc loads psum_data; otherwise acc adds psum_data (wrapping, no saturation). When grp reaches the latched group count - 1, grp resets to 0 and the pixel result is handed to the pipeline. pix increments and wraps at window_size_max; filt increments when pix wraps. Acceptance of the final group of the final pixel of the final filter moves the FSM to DRAIN.
  - DRAIN: wait until the pipeline is empty, then go to DONE.
  - DONE: wb_done=1 for one cycle, busy falls, then go to IDLE.
- psum_valid is ignored in IDLE, DRAIN and DONE. start is ignored outside IDLE.
- Pipeline (fixed, no backpressure):
  - S1: final accumulator value registered.
  - S2: y = saturate_to_DATA_W(acc >>> out_shift), arithmetic shift, range -128..127.
  - S3: activation, then wr_en/wr_addr/wr_data registered.
  - wr_en is high exactly 3 edges after the edge that accepted the final group.
- Address: wr_addr = out_base + running output index. The index increments once per write and wraps modulo 2^ADDR_W.
- Activation:
  - none: y.
  - ReLU: max(y,0).
  - hard-swish: c = clamp(y + (3<<FRAC), 0, 6<<FRAC); result = (y*c*HS_MUL) >>> (10+FRAC), arithmetic, then saturated to DATA_W.
- Exactly filter_number_max*window_size_max writes occur per layer. If either count is 0, the FSM goes straight IDLE -> DRAIN -> DONE with zero writes.
- When psum_valid coincides with the final pixel leaving S1, the new value is still captured correctly (the accumulator and S1 register are independent).

Decomposition:
- Package point_pkg holds: act_mode constants (ACT_NONE, ACT_RELU, ACT_HSWISH), FSM state encoding, and the defaults for FRAC and HS_MUL.
- One sub-module: point_activation, the S3 stage. It is a combinational clamp/multiply/shift plus register, instantiated once.

Test Plan:
- Config: groups=1, filters=1, window=4, out_base=100, shift=0, act=none; psums 5,-3,127,200 -> writes at addr 100..103 with data 5,-3,127,127; wb_done exactly once; busy low afterwards.
- Config: groups=3, window=2, shift=2; psums 40,40,40 then -8,-8,-8 -> data 30, -6; each wr_en 3 edges after its third psum.
- Config: act=ReLU, psum -50 -> 0. Config: act=hswish, FRAC=4, psum 32 with shift 0 -> 26; psum -64 -> 0; psum 96 -> 96.
- Config: filters=2, window=3136, groups=1 -> 6272 writes at sequential addresses; last address = out_base+6271; done 3 edges plus 1 after the last psum.
- Reset: pull rst low midway through the layer -> all outputs 0 immediately; then a fresh start with a new config completes correctly. A start pulsed during RUN is ignored and does not change the write count.
- Zero count: window=0 -> no wr_en; wb_done within 3 cycles of start.

Source files
------------

// File: rtl/point_pkg.sv
// Shared definitions for the pointwise-convolution writeback stage:
// activation codes, FSM encoding and a saturation helper.
package point_pkg;

    localparam logic [1:0] ACT_NONE   = 2'd0;
    localparam logic [1:0] ACT_RELU   = 2'd1;
    localparam logic [1:0] ACT_HSWISH = 2'd2;

    localparam int FRAC_DEF   = 4;
    localparam int HS_MUL_DEF = 171;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic signed [31:0] clamp_s32(input logic signed [31:0] v,
                                                     input logic signed [31:0] lo,
                                                     input logic signed [31:0] hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/point_activation.sv
// Final pipeline stage: applies none/ReLU/hard-swish to the requantized value
// and registers the output-buffer write.
module point_activation
    import point_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14,
    parameter int FRAC   = FRAC_DEF,
    parameter int HS_MUL = HS_MUL_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_y,
    input  logic [1:0]               i_mode,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic                     o_wr_en,
    output logic [ADDR_W-1:0]        o_wr_addr,
    output logic [DATA_W-1:0]        o_wr_data
);

    localparam logic signed [31:0] DMIN  = -(32'sd1 <<< (DATA_W-1));
    localparam logic signed [31:0] DMAX  = (32'sd1 <<< (DATA_W-1)) - 32'sd1;
    localparam logic signed [31:0] C_OFF = 32'sd3 <<< FRAC;
    localparam logic signed [31:0] C_TOP = 32'sd6 <<< FRAC;
    localparam logic signed [31:0] HS_K  = HS_MUL;
    localparam int                 HS_SH = 10 + FRAC;

    logic signed [31:0] w_y32;
    logic signed [31:0] w_c;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_act;

    // Activation datapath; hard-swish is y * relu6(y+3) / 6 in fixed point
    always_comb begin
        w_y32  = 32'(i_y);
        w_c    = clamp_s32(w_y32 + C_OFF, 32'sd0, C_TOP);
        w_prod = w_y32 * w_c * HS_K;
        w_act  = w_y32;
        case (i_mode)
            ACT_RELU: begin
                if (w_y32 < 32'sd0) begin
                    w_act = 32'sd0;
                end else begin
                    w_act = w_y32;
                end
            end
            ACT_HSWISH: w_act = clamp_s32(w_prod >>> HS_SH, DMIN, DMAX);
            default:    w_act = w_y32;
        endcase
    end

    // Write-port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en   <= i_valid;
            o_wr_addr <= i_addr;
            o_wr_data <= DATA_W'(w_act);
        end
    end

endmodule

// File: rtl/point_writeback.sv
// Accumulates MAC partial sums across channel groups, requantizes, activates
// and writes one value per output pixel; pulses wb_done when the layer ends.
module point_writeback
    import point_pkg::*;
#(
    parameter int PSUM_W = 20,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14,
    parameter int FRAC   = FRAC_DEF,
    parameter int HS_MUL = HS_MUL_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        out_base,
    input  logic [3:0]               filter_channel_max,
    input  logic [5:0]               filter_number_max,
    input  logic [13:0]              window_size_max,
    input  logic [4:0]               out_shift,
    input  logic [1:0]               act_mode,
    input  logic                     psum_valid,
    input  logic signed [PSUM_W-1:0] psum_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     busy,
    output logic                     wb_done
);

    localparam logic signed [31:0] DMIN = -(32'sd1 <<< (DATA_W-1));
    localparam logic signed [31:0] DMAX = (32'sd1 <<< (DATA_W-1)) - 32'sd1;
    localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t                    r_state;
    logic [3:0]                r_grp_last;
    logic [5:0]                r_fnum;
    logic [13:0]               r_win;
    logic [4:0]                r_shift;
    logic [1:0]                r_mode;
    logic [3:0]                r_grp;
    logic [13:0]               r_pix;
    logic [5:0]                r_filt;
    logic [ADDR_W-1:0]         r_addr;
    logic signed [PSUM_W-1:0]  r_acc;
    logic                      r_hand;
    logic                      r_s1_v;
    logic signed [PSUM_W-1:0]  r_s1_acc;
    logic                      r_s2_v;
    logic signed [DATA_W-1:0]  r_s2_y;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_pix_last;
    logic                      w_filt_last;
    logic                      w_pipe_empty;
    logic signed [PSUM_W-1:0]  w_acc_next;
    logic signed [PSUM_W-1:0]  w_shifted;
    logic signed [DATA_W-1:0]  w_y;

    // Counter terminal conditions, accumulator update and S2 requantization
    always_comb begin
        w_pix_last   = (r_pix == r_win - 14'd1);
        w_filt_last  = (r_filt == r_fnum - 6'd1);
        w_pipe_empty = !r_hand && !r_s1_v && !r_s2_v;
        if (r_grp == 4'd0) begin
            w_acc_next = psum_data;
        end else begin
            w_acc_next = r_acc + psum_data;
        end
        w_shifted = r_s1_acc >>> r_shift;
        w_y       = DATA_W'(clamp_s32(32'(w_shifted), DMIN, DMAX));
    end

    // Layer-control FSM with group/pixel/filter counters and write address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_grp_last <= 4'd0;
            r_fnum     <= 6'd0;
            r_win      <= 14'd0;
            r_shift    <= 5'd0;
            r_mode     <= 2'd0;
            r_grp      <= 4'd0;
            r_pix      <= 14'd0;
            r_filt     <= 6'd0;
            r_addr     <= '0;
            r_acc      <= '0;
            r_hand     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_hand <= 1'b0;
            if (r_s2_v) begin
                r_addr <= r_addr + ADDR_ONE;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_grp_last <= (filter_channel_max == 4'd0) ? 4'd0 : filter_channel_max - 4'd1;
                        r_fnum     <= filter_number_max;
                        r_win      <= window_size_max;
                        r_shift    <= out_shift;
                        r_mode     <= act_mode;
                        r_grp      <= 4'd0;
                        r_pix      <= 14'd0;
                        r_filt     <= 6'd0;
                        r_addr     <= out_base;
                        r_busy     <= 1'b1;
                        if (filter_number_max == 6'd0 || window_size_max == 14'd0) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (psum_valid) begin
                        r_acc <= w_acc_next;
                        if (r_grp == r_grp_last) begin
                            r_grp  <= 4'd0;
                            r_hand <= 1'b1;
                            if (w_pix_last) begin
                                r_pix  <= 14'd0;
                                r_filt <= r_filt + 6'd1;
                                if (w_filt_last) begin
                                    r_state <= ST_DRAIN;
                                end
                            end else begin
                                r_pix <= r_pix + 14'd1;
                            end
                        end else begin
                            r_grp <= r_grp + 4'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // S1/S2 registers; S1 copies the accumulator so a new pixel can start at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v   <= 1'b0;
            r_s1_acc <= '0;
            r_s2_v   <= 1'b0;
            r_s2_y   <= '0;
        end else begin
            r_s1_v   <= r_hand;
            r_s1_acc <= r_acc;
            r_s2_v   <= r_s1_v;
            r_s2_y   <= w_y;
        end
    end

    point_activation #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FRAC   (FRAC),
        .HS_MUL (HS_MUL)
    ) u_act (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (r_s2_v),
        .i_y       (r_s2_y),
        .i_mode    (r_mode),
        .i_addr    (r_addr),
        .o_wr_en   (wr_en),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data)
    );

    assign busy    = r_busy;
    assign wb_done = r_done;

endmodule

// File: tb/tb_point_writeback.sv
// Self-checking bench for point_writeback: directed and randomized layers
// compared against an arithmetic reference model of the writeback rules.
module tb_point_writeback;

    localparam int PSUM_W = 20;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 14;
    localparam int FRAC   = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     start = 1'b0;
    logic [ADDR_W-1:0]        out_base = '0;
    logic [3:0]               filter_channel_max = '0;
    logic [5:0]               filter_number_max = '0;
    logic [13:0]              window_size_max = '0;
    logic [4:0]               out_shift = '0;
    logic [1:0]               act_mode = '0;
    logic                     psum_valid = 1'b0;
    logic signed [PSUM_W-1:0] psum_data = '0;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     busy;
    logic                     wb_done;

    point_writeback dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .out_base           (out_base),
        .filter_channel_max (filter_channel_max),
        .filter_number_max  (filter_number_max),
        .window_size_max    (window_size_max),
        .out_shift          (out_shift),
        .act_mode           (act_mode),
        .psum_valid         (psum_valid),
        .psum_data          (psum_data),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .busy               (busy),
        .wb_done            (wb_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_seen = 0;
    int done_cyc = 0;
    int wr_seen = 0;
    int exp_d[$];
    int exp_a[$];
    int exp_c[$];
    int stim[$];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat8(input int v);
        if (v < -128) return -128;
        if (v > 127) return 127;
        return v;
    endfunction

    function automatic int model(input logic signed [19:0] acc, input int sh, input int mode);
        int y;
        int c;
        y = sat8(int'(acc) >>> sh);
        if (mode == 1) return (y < 0) ? 0 : y;
        if (mode == 2) begin
            c = y + (3 << FRAC);
            if (c < 0) c = 0;
            if (c > (6 << FRAC)) c = 6 << FRAC;
            return sat8((y * c * 171) >>> (10 + FRAC));
        end
        return y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en === 1'b1) begin
            wr_seen++;
            if (exp_d.size() == 0) begin
                check("wr_unexpected", 32'(wr_en), 0);
            end else begin
                check("wr_data", 32'($signed(wr_data)), exp_d.pop_front());
                check("wr_addr", 32'(wr_addr), exp_a.pop_front());
                check("wr_latency", cyc, exp_c.pop_front());
            end
        end
        if (wb_done === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
    endtask

    task automatic run_layer(input int grp, input int filt, input int win, input int base,
                             input int sh, input int mode, input int gaps, input int poke);
        int g_eff;
        int idx;
        int v;
        int last_acc;
        logic signed [19:0] pv;
        logic signed [19:0] accm;
        g_eff = (grp == 0) ? 1 : grp;
        idx = 0;
        accm = '0;
        wr_seen = 0;
        done_seen = 0;
        out_base = ADDR_W'(base);
        filter_channel_max = 4'(grp);
        filter_number_max = 6'(filt);
        window_size_max = 14'(win);
        out_shift = 5'(sh);
        act_mode = 2'(mode);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_rise", 32'(busy), 1);
        for (int f = 0; f < filt; f++) begin
            for (int p = 0; p < win; p++) begin
                for (int g = 0; g < g_eff; g++) begin
                    if (stim.size() > 0) v = stim.pop_front();
                    else v = int'($urandom_range(0, 4000)) - 2000;
                    if (gaps != 0 && $urandom_range(0, 3) == 0) begin
                        psum_valid = 1'b0;
                        tick();
                    end
                    pv = v[19:0];
                    accm = (g == 0) ? pv : accm + pv;
                    psum_valid = 1'b1;
                    psum_data = pv;
                    if (g == g_eff - 1) begin
                        exp_d.push_back(model(accm, sh, mode));
                        exp_a.push_back((base + idx) % (1 << ADDR_W));
                        exp_c.push_back(cyc + 4);
                        idx++;
                    end
                    tick();
                    if (poke != 0 && f == 0 && p == 0 && g == 0) begin
                        psum_valid = 1'b0;
                        start = 1'b1;
                        out_base = ADDR_W'(base + 7);
                        filter_number_max = 6'd0;
                        tick();
                        start = 1'b0;
                    end
                end
            end
        end
        psum_valid = 1'b0;
        last_acc = cyc;
        for (int k = 0; k < 20 && done_seen == 0; k++) tick();
        tick();
        tick();
        check("done_once", done_seen, 1);
        if (filt * win == 0) check("zero_done_lat", 32'(done_seen > 0 && done_cyc - last_acc <= 3), 1);
        else check("done_latency", done_cyc, last_acc + 4);
        check("wr_count", wr_seen, filt * win);
        check("exp_left", exp_d.size(), 0);
        check("busy_fall", 32'(busy), 0);
    endtask

    initial begin
        #2;
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(wb_done), 0);
        #10 rst = 1'b1;

        stim = {5, -3, 127, 200};
        run_layer(1, 1, 4, 100, 0, 0, 0, 0);
        stim = {40, 40, 40, -8, -8, -8};
        run_layer(3, 1, 2, 200, 2, 0, 0, 0);
        stim = {-50, 77};
        run_layer(1, 1, 2, 300, 0, 1, 0, 0);
        stim = {32, -64, 96};
        run_layer(1, 1, 3, 400, 0, 2, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_layer(int'($urandom_range(0, 4)), int'($urandom_range(1, 3)), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 16383)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 3)), 1, 0);
        end
        run_layer(2, 1, 6, 16380, 1, 0, 1, 0);
        run_layer(2, 2, 3, 1000, 1, 1, 1, 1);
        run_layer(1, 3, 0, 20, 0, 0, 0, 0);
        run_layer(2, 0, 5, 30, 0, 0, 0, 0);

        // reset in the middle of a layer with a write on the port
        wr_seen = 0;
        done_seen = 0;
        out_base = ADDR_W'(600);
        filter_channel_max = 4'd1;
        filter_number_max = 6'd1;
        window_size_max = 14'd8;
        out_shift = 5'd0;
        act_mode = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            psum_valid = 1'b1;
            psum_data = PSUM_W'(i * 10 + 1);
            exp_d.push_back(i * 10 + 1);
            exp_a.push_back(600 + i);
            exp_c.push_back(cyc + 4);
            tick();
        end
        check("pre_rst_wr_en", 32'(wr_en), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_wr_addr", 32'(wr_addr), 0);
        check("mid_rst_wr_data", 32'(wr_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(wb_done), 0);
        exp_d.delete();
        exp_a.delete();
        exp_c.delete();
        psum_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("rst_no_done", done_seen, 0);
        check("rst_no_more_wr", wr_seen, 1);

        run_layer(2, 2, 4, 50, 3, 2, 1, 0);
        run_layer(1, 2, 3136, 500, 4, 2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
